// File: rtl/mul_unit_if.sv
// mul_unit_if: rv32 multiply-op type and the request/result handshake bundle
// shared by the multiply unit and its driver.
package mul_unit_pkg;
    typedef enum logic [2:0] {
        mulop_nop    = 3'd0,
        mulop_mul    = 3'd1,
        mulop_mulh   = 3'd2,
        mulop_mulhsu = 3'd3,
        mulop_mulhu  = 3'd4
    } rv32_mulop;
endpackage

interface mul_unit_if #(parameter int TAG_W = 5);
    import mul_unit_pkg::*;
    logic             i_valid;
    logic             o_ready;
    rv32_mulop        i_mulop;
    logic [31:0]      i_rs1;
    logic [31:0]      i_rs2;
    logic [TAG_W-1:0] i_tag;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_busy;
    modport slave (
        input  i_valid, i_mulop, i_rs1, i_rs2, i_tag, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_tag, o_busy
    );
    modport master (
        output i_valid, i_mulop, i_rs1, i_rs2, i_tag, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_tag, o_busy
    );
endinterface

// File: rtl/mul_unit.sv
// mul_unit: iterative RV32M shift-add multiplier (MUL/MULH/MULHSU/MULHU),
// magnitude multiply with a final sign fix, valid/ready result handshake.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int STEP_BITS = 1,
    parameter int TAG_W     = 5
) (
    input logic        i_clk,
    input logic        i_rst,
    mul_unit_if.slave  io_mul
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           r_state;
    rv32_mulop        r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_neg;
    logic [63:0]      r_acc;
    logic [5:0]       r_cnt;
    logic [31:0]      r_result;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] r_otag;
    logic             r_valid;

    logic        w_accept;
    logic        w_nop;
    logic        w_sa;
    logic        w_sb;
    logic [63:0] w_pp;
    logic [63:0] w_fix;

    assign w_accept = io_mul.i_valid && io_mul.o_ready;
    assign w_nop    = !(io_mul.i_mulop inside {mulop_mul, mulop_mulh, mulop_mulhsu, mulop_mulhu});
    assign w_sa     = (io_mul.i_mulop == mulop_mulh || io_mul.i_mulop == mulop_mulhsu) && io_mul.i_rs1[31];
    assign w_sb     = (io_mul.i_mulop == mulop_mulh) && io_mul.i_rs2[31];
    assign w_pp     = {32'b0, r_a} * {{(64-STEP_BITS){1'b0}}, r_b[STEP_BITS-1:0]};
    assign w_fix    = r_neg ? -r_acc : r_acc;

    assign io_mul.o_ready  = (r_state == IDLE) && !io_mul.i_flush;
    assign io_mul.o_valid  = r_valid;
    assign io_mul.o_result = r_result;
    assign io_mul.o_tag    = r_otag;
    assign io_mul.o_busy   = (r_state != IDLE);

    // r_cnt tracks the bit offset of the current multiplier digit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_op     <= mulop_nop;
            r_a      <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_tag    <= '0;
            r_otag   <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op    <= io_mul.i_mulop;
                    r_tag   <= io_mul.i_tag;
                    r_a     <= w_sa ? -io_mul.i_rs1 : io_mul.i_rs1;
                    r_b     <= w_sb ? -io_mul.i_rs2 : io_mul.i_rs2;
                    r_neg   <= w_sa ^ w_sb;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= w_nop ? DONE : CALC;
                    if (w_nop) begin
                        r_result <= '0;
                        r_otag   <= io_mul.i_tag;
                    end
                end
                CALC: if (io_mul.i_flush) begin
                    r_state <= IDLE;
                end else begin
                    r_acc <= r_acc + (w_pp << r_cnt);
                    r_b   <= r_b >> STEP_BITS;
                    r_cnt <= r_cnt + 6'(STEP_BITS);
                    if (r_cnt == 6'(32 - STEP_BITS))
                        r_state <= FIX;
                end
                FIX: if (io_mul.i_flush) begin
                    r_state <= IDLE;
                end else begin
                    r_result <= (r_op == mulop_mul) ? w_fix[31:0] : w_fix[63:32];
                    r_otag   <= r_tag;
                    r_state  <= DONE;
                end
                // valid rises on the first DONE edge, retires on a later one
                DONE: if (io_mul.i_flush || (r_valid && io_mul.i_ready)) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= 1'b1;
                end
            endcase
        end
    end
endmodule
